// File: rtl/wb_rr_arbiter_if.sv
// Shared Wibone bus bundle: packed per-master request slices plus the single slave port.
// Modport master is the arbiter's view (it masters the slave); slave is the surrounding fabric's view.
interface wb_rr_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int aw          = 32,
   parameter int dw          = 32
);
   logic [NUM_MASTERS*aw-1:0]     wbm_adr_i;
   logic [NUM_MASTERS*dw-1:0]     wbm_dat_i;
   logic [NUM_MASTERS*(dw/8)-1:0] wbm_sel_i;
   logic [NUM_MASTERS-1:0]        wbm_we_i;
   logic [NUM_MASTERS-1:0]        wbm_cyc_i;
   logic [NUM_MASTERS-1:0]        wbm_stb_i;
   logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
   logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
   logic [dw-1:0]                 wbm_dat_o;
   logic [NUM_MASTERS-1:0]        wbm_ack_o;
   logic [NUM_MASTERS-1:0]        wbm_err_o;
   logic [NUM_MASTERS-1:0]        wbm_rty_o;

   logic [aw-1:0]                 wbs_adr_o;
   logic [dw-1:0]                 wbs_dat_o;
   logic [dw/8-1:0]               wbs_sel_o;
   logic                          wbs_we_o;
   logic                          wbs_cyc_o;
   logic                          wbs_stb_o;
   logic [2:0]                    wbs_cti_o;
   logic [1:0]                    wbs_bte_o;
   logic [dw-1:0]                 wbs_dat_i;
   logic                          wbs_ack_i;
   logic                          wbs_err_i;
   logic                          wbs_rty_i;

   modport master (
      input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
   );

   modport slave (
      output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
      output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone N:1 arbiter; 1-cycle arbitration, then combinational pass-through; owner holds the bus until cyc drops.
// Backpressure is the slave's ack/err/rty; optional stall watchdog under WB_ARB_TIMEOUT_EN (err + stb drop after TIMEOUT stalls).
module wb_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int aw          = 32,
   parameter int dw          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   wb_rr_arbiter_if.master        bus,
   output logic [NUM_MASTERS-1:0] grant_o
);
   localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SW = dw / 8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_q, last_d;
   logic          owner_stb;
   logic          timeout_hit;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= OW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      int idx;
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      idx     = 0;
      case (state_q)
         IDLE: begin
            if (|bus.wbm_cyc_i) begin
               state_d = BUSY;
               // Scan farthest-first so the nearest requester after last_q wins.
               for (int i = NUM_MASTERS; i >= 1; i--) begin
                  idx = (int'(last_q) + i) % NUM_MASTERS;
                  if (bus.wbm_cyc_i[OW'(idx)])
                     owner_d = OW'(idx);
               end
            end
         end
         BUSY: begin
            if (!bus.wbm_cyc_i[owner_q]) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_o       = '0;
      owner_stb     = 1'b0;
      bus.wbs_adr_o = '0;
      bus.wbs_dat_o = '0;
      bus.wbs_sel_o = '0;
      bus.wbs_we_o  = 1'b0;
      bus.wbs_cyc_o = 1'b0;
      bus.wbs_cti_o = '0;
      bus.wbs_bte_o = '0;
      if (state_q == BUSY) begin
         grant_o[owner_q] = 1'b1;
         bus.wbs_adr_o    = bus.wbm_adr_i[int'(owner_q)*aw +: aw];
         bus.wbs_dat_o    = bus.wbm_dat_i[int'(owner_q)*dw +: dw];
         bus.wbs_sel_o    = bus.wbm_sel_i[int'(owner_q)*SW +: SW];
         bus.wbs_we_o     = bus.wbm_we_i[owner_q];
         bus.wbs_cyc_o    = bus.wbm_cyc_i[owner_q];
         bus.wbs_cti_o    = bus.wbm_cti_i[int'(owner_q)*3 +: 3];
         bus.wbs_bte_o    = bus.wbm_bte_i[int'(owner_q)*2 +: 2];
         owner_stb        = bus.wbm_stb_i[owner_q];
      end
      bus.wbs_stb_o = owner_stb & ~timeout_hit;
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_cnt_q;
   logic          term;

   assign term        = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
   assign timeout_hit = (state_q == BUSY) && (wd_cnt_q == CW'(TIMEOUT));

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i)
         wd_cnt_q <= '0;
      else if (state_q != BUSY || term || timeout_hit)
         wd_cnt_q <= '0;
      else if (owner_stb)
         wd_cnt_q <= wd_cnt_q + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign bus.wbm_dat_o = bus.wbs_dat_i;
   assign bus.wbm_ack_o = grant_o & {NUM_MASTERS{bus.wbs_ack_i}};
   assign bus.wbm_err_o = grant_o & {NUM_MASTERS{bus.wbs_err_i | timeout_hit}};
   assign bus.wbm_rty_o = grant_o & {NUM_MASTERS{bus.wbs_rty_i}};
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_wb_rr_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         wb_clk_i = 1'b0;
   logic         wb_rst_i;
   logic [N-1:0] grant_o;

   wb_rr_arbiter_if #(.NUM_MASTERS(N), .aw(AW), .dw(DW)) bus ();

   wb_rr_arbiter #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(TO)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .bus      (bus),
      .grant_o  (grant_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // reference model: who owns the bus, who owned it last, stall count
   bit          m_busy;
   int          m_own, m_last, m_wd;
   // master and slave behaviour
   bit          cyc[N], stb[N], we[N];
   logic [AW-1:0] adr[N];
   int          rem[N];
   bit          ack_i, err_i;
   logic [DW-1:0] s_dat;
   bit          allow_new, gap_en;
   int          ack_mode;
   int          n_cmp, n_err;
   logic [N-1:0] prev_grant;
   logic [N-1:0] gq[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] cti_of(int k);
      return (rem[k] > 1) ? 3'b010 : 3'b111;
   endfunction

   function automatic bit to_hit();
      return TO_EN && m_busy && (m_wd == TO);
   endfunction

   function automatic bit exp_stb();
      return m_busy && stb[m_own] && !to_hit();
   endfunction

   task automatic start(input int k, input int beats);
      cyc[k] = 1'b1;
      stb[k] = 1'b1;
      rem[k] = beats;
      adr[k] = $urandom;
      we[k]  = 1'($urandom % 2);
   endtask

   task automatic apply();
      for (int k = 0; k < N; k++) begin
         bus.wbm_adr_i[k*AW +: AW] = adr[k];
         bus.wbm_dat_i[k*DW +: DW] = {adr[k][15:0], 16'(k)};
         bus.wbm_sel_i[k*4 +: 4]   = 4'hf;
         bus.wbm_we_i[k]           = we[k];
         bus.wbm_cyc_i[k]          = cyc[k];
         bus.wbm_stb_i[k]          = stb[k];
         bus.wbm_cti_i[k*3 +: 3]   = cti_of(k);
         bus.wbm_bte_i[k*2 +: 2]   = 2'b00;
      end
      bus.wbs_ack_i = ack_i;
      bus.wbs_err_i = err_i;
      bus.wbs_rty_i = 1'b0;
      bus.wbs_dat_i = s_dat;
   endtask

   task automatic slave_decide();
      bit resp;
      ack_i = 1'b0;
      err_i = 1'b0;
      resp  = 1'b0;
      s_dat = $urandom;
      if (exp_stb()) begin
         if (ack_mode == 1) resp = 1'b1;
         else if (ack_mode == 2) resp = (m_wd >= 2) || ($urandom % 2 == 0);
      end
      if (resp) begin
         if (ack_mode == 2 && $urandom % 8 == 0) err_i = 1'b1;
         else ack_i = 1'b1;
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      eg = '0;
      if (m_busy) eg[m_own] = 1'b1;
      chk("grant", 64'(grant_o), 64'(eg));
      chk("wbs_cyc", 64'(bus.wbs_cyc_o), 64'(m_busy && cyc[m_own]));
      chk("wbs_stb", 64'(bus.wbs_stb_o), 64'(exp_stb()));
      chk("wbs_adr", 64'(bus.wbs_adr_o), m_busy ? 64'(adr[m_own]) : 64'd0);
      chk("wbs_we", 64'(bus.wbs_we_o), 64'(m_busy && we[m_own]));
      chk("wbs_cti", 64'(bus.wbs_cti_o), m_busy ? 64'(cti_of(m_own)) : 64'd0);
      chk("ack_vec", 64'(bus.wbm_ack_o), 64'(eg & {N{ack_i}}));
      chk("err_vec", 64'(bus.wbm_err_o), 64'(eg & {N{err_i | to_hit()}}));
      chk("rty_vec", 64'(bus.wbm_rty_o), 64'd0);
      chk("rd_dat", 64'(bus.wbm_dat_o), 64'(s_dat));
      if (grant_o != prev_grant && grant_o != '0) gq.push_back(grant_o);
      prev_grant = grant_o;
   endtask

   task automatic refresh();
      slave_decide();
      apply();
      #1;
      check_outputs();
   endtask

   task automatic cycle();
      bit t;
      int owner;
      bit dropped[N];
      @(posedge wb_clk_i);
      #1;
      t     = m_busy && (ack_i || err_i || to_hit());
      owner = m_own;
      if (!m_busy || t) m_wd = 0;
      else if (stb[m_own]) m_wd++;
      if (!m_busy) begin
         for (int off = 1; off <= N; off++) begin
            int k;
            k = (m_last + off) % N;
            if (!m_busy && cyc[k]) begin
               m_busy = 1'b1;
               m_own  = k;
            end
         end
      end else if (!cyc[m_own]) begin
         m_busy = 1'b0;
         m_last = m_own;
      end
      for (int k = 0; k < N; k++) dropped[k] = 1'b0;
      if (t) begin
         rem[owner]--;
         adr[owner] = adr[owner] + 4;
         if (rem[owner] <= 0) begin
            cyc[owner]     = 1'b0;
            stb[owner]     = 1'b0;
            dropped[owner] = 1'b1;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (allow_new && !cyc[k] && !dropped[k] && $urandom % 4 == 0)
            start(k, $urandom_range(1, 4));
         if (cyc[k]) stb[k] = gap_en ? ($urandom % 4 != 0) : 1'b1;
      end
      slave_decide();
      apply();
      #1;
      check_outputs();
   endtask

   task automatic clear_masters();
      for (int k = 0; k < N; k++) begin
         cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; rem[k] = 0; adr[k] = '0;
      end
      ack_i = 1'b0;
      err_i = 1'b0;
   endtask

   task automatic do_reset();
      wb_rst_i = 1'b0;
      m_busy   = 1'b0;
      m_own    = 0;
      m_last   = N - 1;
      m_wd     = 0;
      #1;
      check_outputs();
      chk("rst_cyc", 64'(bus.wbs_cyc_o), 64'd0);
      chk("rst_grant", 64'(grant_o), 64'd0);
      clear_masters();
      refresh();
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b1;
   endtask

   initial begin
      int n1, stalls;
      bit seen;
      n_cmp = 0; n_err = 0; prev_grant = '0;
      allow_new = 1'b0; gap_en = 1'b0; ack_mode = 1;
      clear_masters();
      s_dat = '0;
      apply();
      do_reset();

      // single write from master 2, ack two cycles after request
      start(2, 1);
      adr[2] = 32'h100; we[2] = 1'b1;
      ack_mode = 0;
      refresh();
      chk("t1_idle", 64'(grant_o), 64'd0);
      cycle();
      chk("t1_grant", 64'(grant_o), 64'b0100);
      chk("t1_adr", 64'(bus.wbs_adr_o), 64'h100);
      ack_mode = 1;
      cycle();
      chk("t1_ack", 64'(bus.wbm_ack_o), 64'b0100);
      cycle();
      chk("t1_ack_once", 64'(bus.wbm_ack_o), 64'd0);
      repeat (2) cycle();

      // three simultaneous requesters from reset
      do_reset();
      gq.delete();
      start(0, 1); start(1, 1); start(3, 1);
      refresh();
      repeat (12) cycle();
      chk("rr_count", 64'(gq.size()), 64'd3);
      if (gq.size() == 3) begin
         chk("rr_first", 64'(gq[0]), 64'b0001);
         chk("rr_second", 64'(gq[1]), 64'b0010);
         chk("rr_third", 64'(gq[2]), 64'b1000);
      end

      // 4-beat burst by master 1 while master 0 waits
      start(1, 4);
      refresh();
      cycle();
      chk("b_grant0", 64'(grant_o), 64'b0010);
      start(0, 1);
      refresh();
      gq.delete();
      n1 = 0;
      if (bus.wbm_ack_o[1]) n1++;
      repeat (12) begin
         cycle();
         if (bus.wbm_ack_o[1]) begin
            n1++;
            chk("b_hold", 64'(grant_o), 64'b0010);
         end
      end
      chk("b_acks", 64'(n1), 64'd4);
      chk("b_next", gq.size() > 0 ? 64'(gq[0]) : 64'd0, 64'b0001);

      // reset asserted in the middle of a master 3 burst
      start(3, 10);
      refresh();
      repeat (3) cycle();
      chk("r_owner", 64'(grant_o), 64'b1000);
      #1;
      do_reset();
      start(0, 1); start(3, 1);
      refresh();
      cycle();
      chk("r_first", 64'(grant_o), 64'b0001);
      repeat (6) cycle();

      // slave never answers master 0
      ack_mode = 0;
      start(0, 1);
      refresh();
      cycle();
      chk("to_grant", 64'(grant_o), 64'b0001);
      stalls = bus.wbs_stb_o ? 1 : 0;
      seen   = 1'b0;
      repeat (14) begin
         cycle();
         if (bus.wbm_err_o[0] && !seen) begin
            seen = 1'b1;
            chk("to_at", 64'(stalls), 64'(TO));
            chk("to_stb", 64'(bus.wbs_stb_o), 64'd0);
         end else if (!seen && bus.wbs_stb_o) begin
            stalls++;
         end
      end
      chk("to_seen", 64'(seen), 64'(TO_EN));
      cyc[0] = 1'b0; stb[0] = 1'b0; rem[0] = 0;
      ack_mode = 1;
      refresh();
      repeat (3) cycle();

      // randomized contention with stb gaps and err responses
      allow_new = 1'b1; gap_en = 1'b1; ack_mode = 2;
      repeat (400) cycle();
      allow_new = 1'b0;
      repeat (40) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 Parameter aw, default 32, address width.
REQ-003 Parameter dw, default 32, data width; sel width is dw/8.
REQ-004 Parameter TIMEOUT, default 255, watchdog limit in cycles; used only with WB_ARB_TIMEOUT_EN.
REQ-005 Clock and reset SHALL be: wb_clk_i clock; wb_rst_i reset, asynchronous, active-low.
REQ-006 Port wbm_adr_i in NUM_MASTERS*aw; packed master addresses, master k at slice k.
REQ-007 Port wbm_dat_i in NUM_MASTERS*dw; packed master write data.
REQ-008 Port wbm_sel_i in NUM_MASTERS*dw/8; packed byte selects.
REQ-009 Ports wbm_we_i, wbm_cyc_i and wbm_stb_i in NUM_MASTERS; one bit per master.
REQ-010 Ports wbm_cti_i in NUM_MASTERS*3 and wbm_bte_i in NUM_MASTERS*2; packed burst tags.
REQ-011 Port wbm_dat_o out dw; slave read data broadcast to all masters.
REQ-012 Ports wbm_ack_o, wbm_err_o and wbm_rty_o out NUM_MASTERS; per-master terminations.
REQ-013 Ports wbs_adr_o aw, wbs_dat_o dw, wbs_sel_o dw/8, wbs_we_o 1, wbs_cyc_o 1, wbs_stb_o 1, wbs_cti_o 3 and wbs_bte_o 2, all out; shared slave side.
REQ-014 Ports wbs_dat_i in dw, wbs_ack_i in 1, wbs_err_i in 1 and wbs_rty_i in 1; slave responses.
REQ-015 Port grant_o out NUM_MASTERS; one-hot current owner, all zero when idle.

Function
REQ-016 The FSM SHALL have two states, IDLE and BUSY.
REQ-017 In IDLE with any wbm_cyc_i high, the next clock edge SHALL select the owner, enter BUSY and set grant_o; arbitration latency is one cycle.
REQ-018 Owner selection SHALL be round-robin: the first requester found scanning from (last_owner+1) mod NUM_MASTERS upward with wrap.
REQ-019 In BUSY, all wbs_* outputs except cyc/stb SHALL combinationally follow the owner's slices.
REQ-020 In BUSY, wbs_cyc_o/wbs_stb_o SHALL follow the owner's cyc/stb.
REQ-021 In IDLE, wbs_cyc_o and wbs_stb_o SHALL be 0; other wbs_* outputs are 0.
REQ-022 wbs_ack_i, wbs_err_i and wbs_rty_i SHALL route combinationally to the owner's bit only; all non-owner bits are 0; in IDLE all bits are 0.
REQ-023 Ownership SHALL be held while the owner's wbm_cyc_i is high, including across bursts (any cti) and stb gaps; requests from other masters never preempt.
REQ-024 When the owner's wbm_cyc_i samples low, the FSM SHALL return to IDLE and update last_owner; at least one IDLE cycle separates consecutive ownerships.
REQ-025 An owner dropping cyc while other masters request SHALL give the grant, after the IDLE cycle, to the round-robin next requester.
REQ-026 A master raising cyc while another owns the bus SHALL see no ack/err/rty until it is granted.

Reset
REQ-027 Assertion of wb_rst_i low SHALL immediately force state IDLE, grant_o 0, all wbs_* outputs 0, all wbm_ack/err/rty_o 0 and the watchdog counter 0.
REQ-028 Reset SHALL set last_owner to NUM_MASTERS-1 so master 0 wins the first arbitration.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no termination to the owner.
REQ-030 Reset release SHALL be taken synchronously to wb_clk_i.

Configuration
REQ-031 With macro WB_ARB_TIMEOUT_EN defined, a counter SHALL increment each BUSY cycle with wbs_stb_o high and no ack/err/rty, and clear on any termination or on IDLE.
REQ-032 With WB_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT the arbiter SHALL, for one cycle, drive the owner's wbm_err_o high and force wbs_stb_o low, then clear the counter; ownership is unchanged.
REQ-033 Without WB_ARB_TIMEOUT_EN, no counter SHALL exist and err SHALL pass through from the slave only.

Verification
REQ-034 Reset, then master 2 cyc/stb write to 0x100 with slave ack in 2 cycles -> grant_o=0100 one cycle later; wbs_adr_o=0x100; wbm_ack_o=0100 for exactly one cycle.
REQ-035 Masters 0, 1 and 3 request together from reset, each doing one single access -> grant order 0, 1, 3, each separated by one IDLE cycle.
REQ-036 Master 1 performs a 4-beat incrementing burst (cti 010, then 111) while master 0 requests -> grant_o stays 0010 for all 4 acks; master 0 is granted after master 1 drops cyc.
REQ-037 Reset pulled low mid-burst of master 3 -> wbs_cyc_o=0 and grant_o=0 in the same cycle; after release, master 0 wins the first arbitration.
REQ-038 With WB_ARB_TIMEOUT_EN and TIMEOUT=8, slave never acks master 0 -> wbm_err_o[0]=1 after 8 stalled cycles and wbs_stb_o=0 that cycle; without the macro, the bus stalls indefinitely.
